// File: rtl/sprite_drawer.sv
// Sprite blitter: scans an SPR_W x SPR_H ROM sprite onto the vga_adapter plot bus.
// Define SPRITE_DRAWER_ERASE_EN to repaint the previous sprite rectangle with BG_COLOUR first.
module sprite_drawer #(
  parameter int       SPR_W     = 8,
  parameter int       SPR_H     = 8,
  parameter int       ADDR_W    = 6,
  parameter int       X_MAX     = 159,
  parameter int       Y_MAX     = 119,
  parameter bit [2:0] TRANSP    = 3'b101,
  parameter bit [2:0] BG_COLOUR = 3'b000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        pos_x,
  input  logic [6:0]        pos_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [2:0] {
    IDLE, ERASE, DRAW, FLUSH, FIN
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [7:0]    r_cur_x;
  logic [6:0]    r_cur_y;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic          r_pv;
  logic          r_perase;
  logic          r_onscr;

  logic          w_scan;
  logic          w_last;
  logic          w_do_erase;
  logic [7:0]    w_bx;
  logic [6:0]    w_by;
  logic [8:0]    w_sx;
  logic [7:0]    w_sy;

`ifdef SPRITE_DRAWER_ERASE_EN
  logic [7:0] r_prev_x;
  logic [6:0] r_prev_y;
  logic       r_prev_valid;

  assign w_do_erase = r_prev_valid;
  assign w_bx = (r_state == ERASE) ? r_prev_x : r_cur_x;
  assign w_by = (r_state == ERASE) ? r_prev_y : r_cur_y;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_prev_valid <= 1'b0;
    end else if (r_state == FIN) begin
      r_prev_x     <= r_cur_x;
      r_prev_y     <= r_cur_y;
      r_prev_valid <= 1'b1;
    end
  end
`else
  assign w_do_erase = 1'b0;
  assign w_bx = r_cur_x;
  assign w_by = r_cur_y;
`endif

  assign w_scan = (r_state == ERASE) || (r_state == DRAW);
  assign w_last = (r_col == CW'(SPR_W - 1)) && (r_row == RW'(SPR_H - 1));

  // One spare bit so a carry reads as off-screen instead of wrapping
  assign w_sx = {1'b0, w_bx} + 9'(r_col);
  assign w_sy = {1'b0, w_by} + 8'(r_row);

  assign rom_addr = ADDR_W'(r_row) * ADDR_W'(SPR_W) + ADDR_W'(r_col);

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == FIN);
  assign x      = r_x;
  assign y      = r_y;
  assign colour = !r_pv ? 3'b000 : (r_perase ? BG_COLOUR : rom_data);
  assign plot   = r_pv && r_onscr && (r_perase || (rom_data != TRANSP));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_do_erase ? ERASE : DRAW;
      ERASE:   if (w_last) w_next = DRAW;
      DRAW:    if (w_last) w_next = FLUSH;
      FLUSH:   w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_pv     <= 1'b0;
      r_perase <= 1'b0;
      r_onscr  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pv     <= w_scan;
      r_perase <= (r_state == ERASE);
      if (r_state == IDLE && start) begin
        r_cur_x <= pos_x;
        r_cur_y <= pos_y;
      end
      if (w_scan) begin
        r_x     <= w_sx[7:0];
        r_y     <= w_sy[6:0];
        r_onscr <= (w_sx <= 9'(X_MAX)) && (w_sy <= 8'(Y_MAX));
        if (r_col == CW'(SPR_W - 1)) begin
          r_col <= '0;
          r_row <= w_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule
